// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths and the completer FSM state type.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_slv_state_e;

endpackage

// File: rtl/apb_mem_array.sv
// Word storage for the APB completer: synchronous write, combinational read,
// synchronous clear of every word on reset.
module apb_mem_array #(
    parameter int DEPTH      = 32,
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int AWP1 = AW + 1;
    localparam logic [AW:0] DEPTH_C = AWP1'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Storage update: clear everything on reset, otherwise commit one word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && ({1'b0, i_waddr} < DEPTH_C)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port; indices past the end (non power-of-two depth) read as zero.
    always_comb begin
        if ({1'b0, i_raddr} < DEPTH_C) begin
            o_rdata = r_mem[i_raddr];
        end else begin
            o_rdata = '0;
        end
    end

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer memory: word-addressed storage with a fixed number of wait
// states and an error response for addresses at or beyond MEM_DEPTH.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = APB_DATA_WIDTH,
    parameter int MEM_DEPTH   = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  pselx,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr
);

    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

    apb_slv_state_e        r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_pready;
    logic                  r_pslverr;
    logic [DATA_WIDTH-1:0] r_prdata;

    logic [ADDR_WIDTH-1:0] w_addr_sel;
    logic                  w_write_sel;
    logic                  w_oor;
    logic [DATA_WIDTH-1:0] w_mem_rdata;
    logic [DATA_WIDTH-1:0] w_rd_value;
    logic                  w_complete;
    logic                  w_we;

    // With zero wait states the response is formed at the setup edge, so the
    // live bus address is used in IDLE and the latched one in ACCESS.
    always_comb begin
        case (r_state)
            IDLE: begin
                w_addr_sel  = paddr;
                w_write_sel = pwrite;
            end
            ACCESS: begin
                w_addr_sel  = r_addr;
                w_write_sel = r_write;
            end
            default: begin
                w_addr_sel  = r_addr;
                w_write_sel = r_write;
            end
        endcase
    end

    // Full-width unsigned compare, so high addresses never alias into the array.
    assign w_oor      = (w_addr_sel >= DEPTH_A);
    assign w_rd_value = (!w_oor && !w_write_sel) ? w_mem_rdata : '0;
    assign w_complete = (r_state == ACCESS) && pselx && penable && r_pready;
    assign w_we       = w_complete && r_write && !w_oor;

    apb_mem_array #(
        .DEPTH      (MEM_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (MEM_AW)
    ) u_mem (
        .i_clk   (pclk),
        .i_rst   (preset),
        .i_we    (w_we),
        .i_waddr (r_addr[MEM_AW-1:0]),
        .i_wdata (r_wdata),
        .i_raddr (w_addr_sel[MEM_AW-1:0]),
        .o_rdata (w_mem_rdata)
    );

    // Transfer FSM, wait counter and registered response.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (pselx && !penable) begin
                        r_state <= ACCESS;
                        r_addr  <= paddr;
                        r_write <= pwrite;
                        r_wdata <= pwdata;
                        r_cnt   <= WAIT_C;
                        if (WAIT_C == 4'd0) begin
                            r_pready  <= 1'b1;
                            r_pslverr <= w_oor;
                            r_prdata  <= w_rd_value;
                        end
                    end
                end
                ACCESS: begin
                    if (!pselx || w_complete) begin
                        r_state   <= IDLE;
                        r_cnt     <= 4'd0;
                        r_pready  <= 1'b0;
                        r_pslverr <= 1'b0;
                        r_prdata  <= '0;
                    end else if (!r_pready) begin
                        if (r_cnt > 4'd1) begin
                            r_cnt <= r_cnt - 4'd1;
                        end else begin
                            r_cnt     <= 4'd0;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_oor;
                            r_prdata  <= w_rd_value;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign pready  = r_pready;
    assign pslverr = r_pslverr;
    assign prdata  = r_prdata;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances (0, 2 and 3 wait states) checked
// every cycle against a transfer-level model of the APB completer.
module tb_apb_slave_mem;

    logic        pclk;
    logic        rst    [3];
    logic        sel    [3];
    logic        en     [3];
    logic        wr_i   [3];
    logic [31:0] ad     [3];
    logic [31:0] wd     [3];
    logic        rdy_o  [3];
    logic [31:0] rd_o   [3];
    logic        err_o  [3];

    logic        exp_rdy [3];
    logic [31:0] exp_rd  [3];
    logic        exp_err [3];
    logic [31:0] mdl [3][32];

    bit chk_en;
    int n_cmp;
    int n_bad;

    apb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(32), .WAIT_CYCLES(0)) u_dut0 (
        .pclk(pclk), .preset(rst[0]), .pselx(sel[0]), .penable(en[0]), .pwrite(wr_i[0]),
        .paddr(ad[0]), .pwdata(wd[0]), .pready(rdy_o[0]), .prdata(rd_o[0]), .pslverr(err_o[0]));
    apb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(32), .WAIT_CYCLES(2)) u_dut1 (
        .pclk(pclk), .preset(rst[1]), .pselx(sel[1]), .penable(en[1]), .pwrite(wr_i[1]),
        .paddr(ad[1]), .pwdata(wd[1]), .pready(rdy_o[1]), .prdata(rd_o[1]), .pslverr(err_o[1]));
    apb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(32), .WAIT_CYCLES(3)) u_dut2 (
        .pclk(pclk), .preset(rst[2]), .pselx(sel[2]), .penable(en[2]), .pwrite(wr_i[2]),
        .paddr(ad[2]), .pwdata(wd[2]), .pready(rdy_o[2]), .prdata(rd_o[2]), .pslverr(err_o[2]));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic int wait_of(input int d);
        case (d)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic set_exp(input int d, input logic r, input logic [31:0] v, input logic e);
        exp_rdy[d] = r;
        exp_rd[d]  = v;
        exp_err[d] = e;
    endtask

    // One compare process: every DUT, every cycle, all three response outputs.
    always @(negedge pclk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("dut%0d_resp", d),
                    {30'h0, rdy_o[d], err_o[d], rd_o[d]},
                    {30'h0, exp_rdy[d], exp_err[d], exp_rd[d]});
            end
        end
    end

    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk); #1;
            sel[d] = 1'b0;
            en[d]  = 1'b0;
            ad[d]  = $urandom;
            set_exp(d, 1'b0, 32'h0, 1'b0);
        end
    endtask

    // One transfer. abort_at / rst_at give the access-cycle index at which
    // pselx drops or preset is raised (-1 = never); pen_delay holds penable low.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input int abort_at, input int pen_delay, input int rst_at,
                        output logic [31:0] rd, output logic err, output int rise_k, output int hi_cnt);
        int w;
        int lim;
        bit done;
        bit was_rst;
        logic ee;
        logic [31:0] ev;
        w  = wait_of(d);
        ee = (addr >= 32'd32);
        ev = (!wr && !ee) ? mdl[d][addr[4:0]] : 32'h0;
        rd = 32'h0; err = 1'b0; rise_k = -1; hi_cnt = 0;
        lim = (w > pen_delay) ? w : pen_delay;
        if (abort_at > lim) lim = abort_at;
        if (rst_at > lim) lim = rst_at;
        @(posedge pclk); #1;
        sel[d] = 1'b1; en[d] = 1'b0; wr_i[d] = wr; ad[d] = addr; wd[d] = data;
        set_exp(d, 1'b0, 32'h0, 1'b0);
        done = 1'b0;
        was_rst = 1'b0;
        for (int k = 0; k <= lim && !done; k++) begin
            @(posedge pclk); #1;
            if (k >= w) set_exp(d, 1'b1, ev, ee);
            else        set_exp(d, 1'b0, 32'h0, 1'b0);
            if (k == rst_at) begin
                rst[d] = 1'b1;
                en[d]  = 1'b1;
                done = 1'b1;
                was_rst = 1'b1;
            end else if (k == abort_at) begin
                sel[d] = 1'b0;
                en[d]  = 1'b0;
                done = 1'b1;
            end else begin
                en[d] = (k >= pen_delay);
                if (en[d] && k >= w) begin
                    done = 1'b1;
                    if (wr && !ee) mdl[d][addr[4:0]] = data;
                end
            end
            @(negedge pclk);
            if (rdy_o[d] === 1'b1) begin
                if (rise_k < 0) rise_k = k;
                hi_cnt++;
                rd  = rd_o[d];
                err = err_o[d];
            end
        end
        if (was_rst) begin
            @(posedge pclk); #1;
            rst[d] = 1'b0;
            sel[d] = 1'b0;
            en[d]  = 1'b0;
            set_exp(d, 1'b0, 32'h0, 1'b0);
            for (int i = 0; i < 32; i++) mdl[d][i] = 32'h0;
        end
    endtask

    logic [31:0] rd;
    logic        err;
    int          rk;
    int          hc;
    bit          rwr;
    logic [31:0] raddr;
    logic [31:0] rdat;
    int          rab;
    int          rpd;
    int          rsel;
    int          rlim;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        chk_en = 1'b0;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            sel[d] = 1'($urandom); en[d] = 1'($urandom); wr_i[d] = 1'($urandom);
            ad[d] = $urandom_range(0, 40); wd[d] = $urandom;
            set_exp(d, 1'b0, 32'h0, 1'b0);
            for (int i = 0; i < 32; i++) mdl[d][i] = 32'h0;
        end

        // Reset for two edges with random bus activity, outputs must stay low.
        @(posedge pclk); #1;
        chk_en = 1'b1;
        for (int d = 0; d < 3; d++) begin
            sel[d] = 1'($urandom); en[d] = 1'($urandom); wr_i[d] = 1'($urandom);
            ad[d] = $urandom_range(0, 40); wd[d] = $urandom;
        end
        @(posedge pclk); #1;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b0; sel[d] = 1'b0; en[d] = 1'b0;
        end
        xfer(0, 1'b0, 32'd5, 32'h0, -1, 0, -1, rd, err, rk, hc);
        chk("reset_read5_data", {32'h0, rd}, 64'h0);
        chk("reset_read5_rise", 64'(rk), 64'd0);

        // Zero-wait write then back-to-back read of the same word.
        xfer(0, 1'b1, 32'd3, 32'hDEADBEEF, -1, 0, -1, rd, err, rk, hc);
        chk("zw_write_rise", 64'(rk), 64'd0);
        chk("zw_write_hi", 64'(hc), 64'd1);
        xfer(0, 1'b0, 32'd3, 32'h0, -1, 0, -1, rd, err, rk, hc);
        chk("zw_read_data", {32'h0, rd}, 64'hDEADBEEF);
        chk("zw_read_err", {63'h0, err}, 64'h0);
        chk("zw_read_rise", 64'(rk), 64'd0);
        idle(0, 1);

        // Out-of-range write/read next to a known word at address 0.
        xfer(0, 1'b1, 32'd0, 32'hCAFE0000, -1, 0, -1, rd, err, rk, hc);
        xfer(0, 1'b1, 32'd32, 32'hA5A5A5A5, -1, 0, -1, rd, err, rk, hc);
        chk("oor_write_err", {63'h0, err}, 64'h1);
        chk("oor_write_data", {32'h0, rd}, 64'h0);
        xfer(0, 1'b0, 32'd32, 32'h0, -1, 0, -1, rd, err, rk, hc);
        chk("oor_read_err", {63'h0, err}, 64'h1);
        chk("oor_read_data", {32'h0, rd}, 64'h0);
        xfer(0, 1'b0, 32'd0, 32'h0, -1, 0, -1, rd, err, rk, hc);
        chk("oor_addr0_data", {32'h0, rd}, 64'hCAFE0000);
        chk("oor_addr0_err", {63'h0, err}, 64'h0);
        idle(0, 1);

        // Three wait states on a preloaded word.
        xfer(2, 1'b1, 32'd7, 32'h12345678, -1, 0, -1, rd, err, rk, hc);
        idle(2, 1);
        xfer(2, 1'b0, 32'd7, 32'h0, -1, 0, -1, rd, err, rk, hc);
        chk("ws3_read_data", {32'h0, rd}, 64'h12345678);
        chk("ws3_read_rise", 64'(rk), 64'd3);
        chk("ws3_read_hi", 64'(hc), 64'd1);
        idle(2, 1);

        // Abort after one access cycle with two wait states.
        xfer(1, 1'b1, 32'd1, 32'h11111111, -1, 0, -1, rd, err, rk, hc);
        idle(1, 1);
        xfer(1, 1'b1, 32'd1, 32'h00000055, 1, 0, -1, rd, err, rk, hc);
        chk("abort_hi", 64'(hc), 64'd0);
        idle(1, 1);
        xfer(1, 1'b0, 32'd1, 32'h0, -1, 0, -1, rd, err, rk, hc);
        chk("abort_old_data", {32'h0, rd}, 64'h11111111);
        idle(1, 1);

        // Reset in the wait cycles of a write.
        xfer(2, 1'b1, 32'd2, 32'h0000ABCD, -1, 0, -1, rd, err, rk, hc);
        xfer(2, 1'b1, 32'd2, 32'h00000077, -1, 0, 1, rd, err, rk, hc);
        xfer(2, 1'b0, 32'd2, 32'h0, -1, 0, -1, rd, err, rk, hc);
        chk("rst_mid_read", {32'h0, rd}, 64'h0);
        idle(2, 1);

        // Randomized traffic: mixed ranges, delayed penable, aborts, gaps.
        for (int d = 0; d < 3; d++) begin
            for (int t = 0; t < 60; t++) begin
                rwr  = 1'($urandom);
                rdat = $urandom;
                rsel = $urandom_range(0, 9);
                if (rsel < 8)       raddr = 32'($urandom_range(0, 31));
                else if (rsel == 8) raddr = 32'($urandom_range(32, 40));
                else                raddr = $urandom;
                rpd  = ($urandom_range(0, 9) < 2) ? $urandom_range(1, 3) : 0;
                rlim = (wait_of(d) > rpd) ? wait_of(d) : rpd;
                rab  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, rlim) : -1;
                xfer(d, rwr, raddr, rdat, rab, rpd, -1, rd, err, rk, hc);
                if ($urandom_range(0, 2) == 0) idle(d, $urandom_range(1, 2));
            end
            idle(d, 1);
        end

        // Full readback of every word; the compare process checks each one.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 32; i++) begin
                xfer(d, 1'b0, 32'(i), 32'h0, -1, 0, -1, rd, err, rk, hc);
            end
            idle(d, 1);
        end

        idle(0, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
